branch_predictor: RTL and testbench

Direct-mapped branch target buffer with per-entry 2-bit saturating counters for the RV32 pipeline. In IF it predicts the next PC from the fetch PC. In EX it takes the resolved branch outcome (BranchE from branch decision) and the computed target, updates its tables, and flags mispredictions with the recovery PC for the hazard/NPC logic.

---
 rtl/branch_predictor.sv | 171 +++++++++++++++++
 tb/tb_branch_predictor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer (BTB) with one 2-bit saturating counter
// per entry, for the RV32 pipeline.
//   IF : predicts the next PC from the fetch PC. This path is purely
//        combinational.
//   EX : takes the resolved branch outcome and the computed target, updates
//        the tables, and flags a misprediction together with the recovery PC.
//
// Parameters
//   ENTRIES  number of BTB entries (power of two, 4..1024)
//   INDEX_W  log2(ENTRIES); index = PC[INDEX_W+1:2], tag = PC[31:INDEX_W+2]
//
// Ports
//   clk, rst_n    clock; synchronous active-low reset sampled on the rising edge
//   PCF           fetch PC to look up
//   PredTakenF    prediction for PCF: taken
//   PredTargetF   predicted next PC (PCF+4 when not predicted taken)
//   UpdateEnE     a valid conditional branch occupies EX
//   PCE           PC of the EX branch
//   BranchE       resolved outcome (1 = taken)
//   BrTargetE     computed branch target
//   PredTakenE    PredTakenF carried down with the instruction
//   PredTargetE   PredTargetF carried down with the instruction
//   MispredictE   prediction was wrong: flush IF/ID and redirect
//   RecoverPCE    correct next PC (BrTargetE if taken, else PCE+4)
//
// Optional feature, macro BP_STATS_EN
//   Adds BranchCount and MispredCount. These are free-running 32-bit event
//   counters that wrap. Prediction behaviour is the same with and without it.
// -----------------------------------------------------------------------------
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int INDEX_W = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PCF,
   output logic        PredTakenF,
   output logic [31:0] PredTargetF,
   input  logic        UpdateEnE,
   input  logic [31:0] PCE,
   input  logic        BranchE,
   input  logic [31:0] BrTargetE,
   input  logic        PredTakenE,
   input  logic [31:0] PredTargetE,
   output logic        MispredictE,
   output logic [31:0] RecoverPCE
`ifdef BP_STATS_EN
   ,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredCount
`endif
);

   localparam int TAG_W = 30 - INDEX_W;

   // 2-bit saturating counter; bit 1 is the taken prediction.
   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_t;

   logic [ENTRIES-1:0] valid_q;
   ctr_t               ctr_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [31:0]        target_mem [ENTRIES];

   // Word alignment makes PC[1:0] irrelevant to the lookup.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

   // ---------------------------------------------------------------------------
   // IF lookup
   // ---------------------------------------------------------------------------
   logic [INDEX_W-1:0] idx_f;
   logic [TAG_W-1:0]   tag_f;
   logic               hit_f;

   assign idx_f = PCF[INDEX_W+1:2];
   assign tag_f = PCF[31:INDEX_W+2];
   assign hit_f = valid_q[idx_f] && (tag_mem[idx_f] == tag_f);

   assign PredTakenF  = hit_f && ctr_q[idx_f][1];
   assign PredTargetF = PredTakenF ? target_mem[idx_f] : PCF + 32'd4;

   // ---------------------------------------------------------------------------
   // EX resolution
   // ---------------------------------------------------------------------------
   logic [INDEX_W-1:0] idx_e;
   logic [TAG_W-1:0]   tag_e;
   logic               hit_e;
   logic               wrong_dir;
   logic               wrong_tgt;

   assign idx_e = PCE[INDEX_W+1:2];
   assign tag_e = PCE[31:INDEX_W+2];
   assign hit_e = valid_q[idx_e] && (tag_mem[idx_e] == tag_e);

   assign wrong_dir = PredTakenE != BranchE;
   assign wrong_tgt = PredTakenE && BranchE && (PredTargetE != BrTargetE);

   assign MispredictE = UpdateEnE && (wrong_dir || wrong_tgt);
   assign RecoverPCE  = !UpdateEnE ? 32'd0 :
                        BranchE    ? BrTargetE : PCE + 32'd4;

   // Next state of the counter being updated, saturating at both ends.
   ctr_t ctr_cur;
   ctr_t ctr_nxt;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path can leave it unassigned and infer a latch.
      ctr_cur = ctr_q[idx_e];
      ctr_nxt = ctr_cur;
      case (ctr_cur)
         STRONG_NT: ctr_nxt = BranchE ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   ctr_nxt = BranchE ? WEAK_T   : STRONG_NT;
         WEAK_T:    ctr_nxt = BranchE ? STRONG_T : WEAK_NT;
         STRONG_T:  ctr_nxt = BranchE ? STRONG_T : WEAK_T;
         default:   ctr_nxt = STRONG_NT;
      endcase
   end

   // Valid bits and counters. These must clear on reset. Reset has priority,
   // so an update presented in the reset cycle is dropped.
   always_ff @(posedge clk) begin
      // NOTE: state is written with non-blocking assignments so that every
      // reader sees pre-edge values. That ordering gives a same-cycle lookup
      // the old contents, with no bypass.
      if (!rst_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= STRONG_NT;
      end else if (UpdateEnE) begin
         if (hit_e) begin
            ctr_q[idx_e] <= ctr_nxt;
         end else if (BranchE) begin
            valid_q[idx_e] <= 1'b1;
            ctr_q[idx_e]   <= WEAK_T;
         end
      end
   end

   // Tag and target storage. This storage is never read without its valid
   // bit, so it has no reset. A taken resolution always rewrites the target.
   // On a hit the tag is rewritten with the value it already holds.
   always_ff @(posedge clk) begin
      // NOTE: the storage arrays are deliberately not reset. Only the write
      // enable honours rst_n, which keeps them plain RAM.
      if (rst_n && UpdateEnE && BranchE) begin
         tag_mem[idx_e]    <= tag_e;
         target_mem[idx_e] <= BrTargetE;
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         BranchCount  <= '0;
         MispredCount <= '0;
      end else begin
         if (UpdateEnE)   BranchCount  <= BranchCount + 32'd1;
         if (MispredictE) MispredCount <= MispredCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor (ENTRIES=64).
//
// Each vector is applied for one clock cycle. Its expected outputs are pushed
// to a scoreboard queue when the inputs are driven. The combinational outputs
// are sampled on the falling edge, popped and compared. The rising edge then
// commits any update.
//
// Counter statistics are checked when BP_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        UpdateEnE;
   logic [31:0] PCE;
   logic        BranchE;
   logic [31:0] BrTargetE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        MispredictE;
   logic [31:0] RecoverPCE;
`ifdef BP_STATS_EN
   logic [31:0] BranchCount;
   logic [31:0] MispredCount;
`endif

   branch_predictor #(.ENTRIES(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCF         (PCF),
      .PredTakenF  (PredTakenF),
      .PredTargetF (PredTargetF),
      .UpdateEnE   (UpdateEnE),
      .PCE         (PCE),
      .BranchE     (BranchE),
      .BrTargetE   (BrTargetE),
      .PredTakenE  (PredTakenE),
      .PredTargetE (PredTargetE),
      .MispredictE (MispredictE),
      .RecoverPCE  (RecoverPCE)
`ifdef BP_STATS_EN
      ,
      .BranchCount (BranchCount),
      .MispredCount(MispredCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic [31:0] pcf;
      logic        upd;
      logic [31:0] pce;
      logic        br;
      logic [31:0] brt;
      logic        pte;
      logic [31:0] ptge;
      logic        exp_pt;
      logic [31:0] exp_tgt;
      logic        exp_mis;
      logic [31:0] exp_rec;
   } vec_t;

   typedef struct {
      logic        pt;
      logic [31:0] tgt;
      logic        mis;
      logic [31:0] rec;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic [31:0] pcf, input logic upd,
                               input logic [31:0] pce, input logic br, input logic [31:0] brt,
                               input logic pte, input logic [31:0] ptge,
                               input logic ept, input logic [31:0] etgt,
                               input logic emis, input logic [31:0] erec);
      vec_t v;
      v.rst_n = r;   v.pcf = pcf;    v.upd = upd;   v.pce = pce;
      v.br = br;     v.brt = brt;    v.pte = pte;   v.ptge = ptge;
      v.exp_pt = ept; v.exp_tgt = etgt; v.exp_mis = emis; v.exp_rec = erec;
      return v;
   endfunction

   // Drive one cycle, score its outputs at mid-cycle, then let the edge commit.
   task automatic run_vec(input vec_t v, input string name);
      exp_t e;
      rst_n       = v.rst_n;
      PCF         = v.pcf;
      UpdateEnE   = v.upd;
      PCE         = v.pce;
      BranchE     = v.br;
      BrTargetE   = v.brt;
      PredTakenE  = v.pte;
      PredTargetE = v.ptge;
      e.pt  = v.exp_pt;
      e.tgt = v.exp_tgt;
      e.mis = v.exp_mis;
      e.rec = v.exp_rec;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check({name, " PredTakenF"},  {31'd0, PredTakenF},  {31'd0, e.pt});
      check({name, " PredTargetF"}, PredTargetF,          e.tgt);
      check({name, " MispredictE"}, {31'd0, MispredictE}, {31'd0, e.mis});
      check({name, " RecoverPCE"},  RecoverPCE,           e.rec);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Columns: rst_n, PCF, upd, PCE, BranchE, BrTargetE, PredTakenE, PredTargetE |
      //          exp PredTakenF, exp PredTargetF, exp MispredictE, exp RecoverPCE
      // Cold lookup after reset.
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0));
      // Mispredicted taken miss: allocate. Same-cycle lookup still sees the old contents.
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
      // Not taken twice: 10 -> 01 -> 00.
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44));
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h100, 0, 32'h44,  0, 32'h44,  0, 32'h44));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0));
      // Taken four times: 00 -> 01 -> 10 -> 11 -> 11.
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100));
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44,  0, 32'h44,  1, 32'h100));
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100));
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h100, 1, 32'h100, 1, 32'h100, 0, 32'h100));
      // One not-taken from saturated 11 leaves 10, so the prediction stays taken.
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 1, 32'h100, 1, 32'h44));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h100, 0, 32'h0));
      // Right direction, wrong target: redirect, and the stored target is replaced.
      vecs.push_back(mk(1, 32'h40, 1, 32'h40, 1, 32'h200, 1, 32'h100, 1, 32'h100, 1, 32'h200));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h200, 0, 32'h0));
      // Same index, different tag: miss.
      vecs.push_back(mk(1, 32'h140, 0, 32'h0, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h0));
      // UpdateEnE=0 gates both EX outputs and must not write.
      vecs.push_back(mk(1, 32'h80, 0, 32'h80, 1, 32'h900, 0, 32'h84,  0, 32'h84,  0, 32'h0));
      vecs.push_back(mk(1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 32'h0));
      // A not-taken miss does not allocate.
      vecs.push_back(mk(1, 32'h80, 1, 32'h80, 0, 32'h900, 0, 32'h84,  0, 32'h84,  0, 32'h84));
      vecs.push_back(mk(1, 32'h80, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h84,  0, 32'h0));
      // PC+4 wraps modulo 2^32 on both the fetch path and the recovery path.
      vecs.push_back(mk(1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0));
      // A taken miss on the alias overwrites the shared entry.
      vecs.push_back(mk(1, 32'h40, 1, 32'h140, 1, 32'h300, 0, 32'h144, 1, 32'h200, 1, 32'h300));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0, 0, 32'h0,   0, 32'h0,   1, 32'h300, 0, 32'h0));
      // Reset together with a taken update. The outputs follow their inputs, and the update is dropped.
      vecs.push_back(mk(0, 32'h140, 1, 32'h40, 1, 32'h500, 0, 32'h44,  1, 32'h300, 1, 32'h500));
      vecs.push_back(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h44,  0, 32'h0));
      vecs.push_back(mk(1, 32'h140, 0, 32'h0, 0, 32'h0,   0, 32'h0,   0, 32'h144, 0, 32'h0));

      // Initial reset. No comparisons are made while the tables are unknown.
      rst_n = 1'b0; PCF = '0; UpdateEnE = 1'b0; PCE = '0; BranchE = 1'b0;
      BrTargetE = '0; PredTakenE = 1'b0; PredTargetE = '0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], $sformatf("v%0d", i));

      // Hand-written sequence: neighbouring indices train independently.
      run_vec(mk(1, 32'h44, 1, 32'h44, 1, 32'h600, 0, 32'h48, 0, 32'h48, 1, 32'h600), "seq_nb0");
      run_vec(mk(1, 32'h48, 1, 32'h48, 1, 32'h700, 0, 32'h4C, 0, 32'h4C, 1, 32'h700), "seq_nb1");
      run_vec(mk(1, 32'h44, 0, 32'h0,  0, 32'h0,   0, 32'h0,  1, 32'h600, 0, 32'h0),  "seq_nb2");
      run_vec(mk(1, 32'h48, 0, 32'h0,  0, 32'h0,   0, 32'h0,  1, 32'h700, 0, 32'h0),  "seq_nb3");
      run_vec(mk(1, 32'h40, 0, 32'h0,  0, 32'h0,   0, 32'h0,  0, 32'h44,  0, 32'h0),  "seq_nb4");

`ifdef BP_STATS_EN
      // Hand-written sequence: the statistics counters.
      // Clear the counters first so the count starts from a known point.
      run_vec(mk(0, 32'h80, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h84, 0, 32'h0), "st_rst");
      check("stats BranchCount after reset",  BranchCount,  32'd0);
      check("stats MispredCount after reset", MispredCount, 32'd0);
      run_vec(mk(1, 32'h80, 1, 32'h80, 1, 32'hA00, 0, 32'h84,  0, 32'h84,  1, 32'hA00), "st0");
      run_vec(mk(1, 32'h80, 1, 32'h80, 1, 32'hA00, 1, 32'hA00, 1, 32'hA00, 0, 32'hA00), "st1");
      run_vec(mk(1, 32'h80, 1, 32'h90, 0, 32'h0,   0, 32'h94,  1, 32'hA00, 0, 32'h94),  "st2");
      check("stats BranchCount", BranchCount,  32'd3);
      check("stats MispredCount", MispredCount, 32'd1);
      run_vec(mk(0, 32'h80, 1, 32'h90, 1, 32'hB00, 0, 32'h94, 1, 32'hA00, 1, 32'hB00), "st_rst2");
      check("stats BranchCount cleared",  BranchCount,  32'd0);
      check("stats MispredCount cleared", MispredCount, 32'd0);
`endif

      if (sb.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
